// File: rtl/rx_buffer.sv
// rtl/rx_buffer.sv - UART receive decode (parity/stop check) feeding a first-word-fall-through FIFO.
// Optional macro RX_ERR_DROP_EN: drop pe/fe frames and count them on err_cnt_o.
module rx_buffer #(
    parameter int DEPTH          = 8,
    parameter int MAX_FRAME_SIZE = 11
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      cr_ds_i,
    input  logic                      cr_s_i,
    input  logic [1:0]                cr_p_i,
    input  logic [MAX_FRAME_SIZE-1:0] frame_i,
    input  logic                      parity_i,
    input  logic                      valid_i,
    input  logic                      pop_i,
    input  logic                      clear_ovr_i,
    output logic [7:0]                data_o,
    output logic                      pe_o,
    output logic                      fe_o,
    output logic                      empty_o,
    output logic                      full_o,
    output logic [$clog2(DEPTH):0]    count_o,
    output logic                      overrun_o,
    output logic [7:0]                err_cnt_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int SW = $clog2(MAX_FRAME_SIZE) + 1;

    logic [9:0]                mem [DEPTH];
    logic [AW-1:0]             wr_ptr;
    logic [AW-1:0]             rd_ptr;
    logic [AW:0]               count;
    logic                      overrun;

    logic                      par_en;
    logic [7:0]                dec_data;
    logic [SW-1:0]             stop_idx;
    logic [MAX_FRAME_SIZE-1:0] shifted;
    logic                      dec_pe;
    logic                      dec_fe;

    logic                      empty;
    logic                      full;
    logic                      accept;
    logic                      do_push;
    logic                      do_pop;
    logic                      ovr_set;
    logic [9:0]                head;

    always_comb begin
        par_en   = (cr_p_i == 2'b01) || (cr_p_i == 2'b10);
        dec_data = cr_ds_i ? frame_i[7:0] : {1'b0, frame_i[6:0]};
        stop_idx = SW'(7) + SW'(cr_ds_i) + SW'(par_en);
        shifted  = frame_i >> stop_idx;
        dec_fe   = !shifted[0] || (cr_s_i && !shifted[1]);
        // cr_p_i[1] is set only for odd mode, which inverts the even-mode check
        dec_pe   = par_en && ((^dec_data) ^ parity_i ^ cr_p_i[1]);
    end

    assign empty = (count == '0);
    assign full  = (count == (AW+1)'(DEPTH));

`ifdef RX_ERR_DROP_EN
    logic       drop;
    logic [7:0] err_cnt;

    assign drop   = valid_i && (dec_pe || dec_fe);
    assign accept = valid_i && !(dec_pe || dec_fe);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_cnt <= '0;
        end else if (clear_ovr_i) begin
            err_cnt <= drop ? 8'd1 : 8'd0;
        end else if (drop && err_cnt != 8'hFF) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end

    assign err_cnt_o = err_cnt;
`else
    assign accept    = valid_i;
    assign err_cnt_o = '0;
`endif

    assign do_pop  = pop_i && !empty;
    assign do_push = accept && (!full || do_pop);
    assign ovr_set = accept && full && !pop_i;

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr] <= {dec_fe, dec_pe, dec_data};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            overrun <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
            if (ovr_set) begin
                overrun <= 1'b1;
            end else if (clear_ovr_i) begin
                overrun <= 1'b0;
            end
        end
    end

    assign head      = mem[rd_ptr];
    assign data_o    = empty ? 8'h00 : head[7:0];
    assign pe_o      = empty ? 1'b0 : head[8];
    assign fe_o      = empty ? 1'b0 : head[9];
    assign empty_o   = empty;
    assign full_o    = full;
    assign count_o   = count;
    assign overrun_o = overrun;

endmodule

// File: doc/rx_buffer.md
Name: rx_buffer

Overview:
Receive-side stage directly downstream of the UART receive front-end. It takes each raw captured frame plus its valid strobe and decodes it using the live control-register fields (data size, stop bits, parity mode). It checks parity and stop bits, then stores the data byte with its error flags in a small FIFO. The register block pops this FIFO when software reads RXDR and builds SR flags from its status outputs.

Parameters:
DEPTH, 8, FIFO entries; power of two, minimum 2.
MAX_FRAME_SIZE, 11, width of the raw frame input.

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
cr_ds_i  in  1  data size: 0 = 7 bits, 1 = 8 bits
cr_s_i  in  1  stop bits: 0 = 1 stop, 1 = 2 stops
cr_p_i  in  2  parity mode: 00 none, 01 even, 10 odd, 11 none
frame_i  in  MAX_FRAME_SIZE  raw frame, bit 0 = first received bit after start
parity_i  in  1  received parity bit, as extracted by the front-end
valid_i  in  1  one-cycle strobe: frame_i/parity_i valid
pop_i  in  1  discard head entry
clear_ovr_i  in  1  clear sticky overrun
data_o  out  8  head data byte
pe_o  out  1  head parity error
fe_o  out  1  head framing error
empty_o  out  1  FIFO empty
full_o  out  1  FIFO full
count_o  out  $clog2(DEPTH)+1  occupancy
overrun_o  out  1  sticky overrun flag
err_cnt_o  out  8  dropped-error-frame counter (optional feature)

Behaviour:
- Clock and reset: single clock clk_i; reset is synchronous and active-high on rst_i.
- Reset clears pointers, count and overrun. After reset: empty_o=1, full_o=0, count_o=0, overrun_o=0, err_cnt_o=0, data_o/pe_o/fe_o=0.
- Decode is combinational on frame_i and uses the CR fields sampled in the valid_i cycle.
  - N = 7 + cr_ds_i.
  - Data = frame_i[N-1:0]; data[7] is forced to 0 when N=7.
  - Parity enabled (P=1) when cr_p_i is 01 or 10.
  - Stop bit(s) at frame_i[N+P], plus frame_i[N+P+1] when cr_s_i=1.
- Parity error (pe) only when P=1:
  - Even mode: pe = XOR(data bits) != parity_i.
  - Odd mode: pe = XOR(data bits) == parity_i.
  - pe is always 0 when parity is disabled.
- Framing error (fe) = any stop bit equal to 0.
- Entry = {fe, pe, data[7:0]}, stored in registered memory.
- Outputs are first-word-fall-through: data_o/pe_o/fe_o show the head entry whenever empty_o=0, and are 0 when empty.
- Latency: entry pushed at edge N is visible and empty_o deasserts after edge N.
- Push occurs on valid_i when not full, or when full with pop_i in the same cycle (count unchanged).
- Pop occurs on pop_i when not empty. pop_i while empty is ignored, with no pointer change.
- Simultaneous push and pop when not full and not empty: count unchanged, both pointers advance.
- Simultaneous push and pop when empty: push only; the new entry becomes head.
- Pointers wrap modulo DEPTH. full_o = (count_o == DEPTH).
- Overrun: valid_i while full with no pop_i drops the frame and sets overrun_o.
  - Existing entries are untouched.
  - overrun_o stays set until clear_ovr_i.
  - If clear_ovr_i and a new overrun occur in the same cycle, set wins.
- CR changes take effect on the next valid_i; already-stored entries are not re-decoded.
- Reset mid-operation discards all entries regardless of valid_i/pop_i in that cycle.

Optional Feature:
RX_ERR_DROP_EN
- Defined: frames with pe or fe are not pushed. err_cnt_o increments by 1 per dropped frame and saturates at 255. It is cleared by reset and by clear_ovr_i. If a drop and clear_ovr_i occur in the same cycle, the count ends at 1. Error frames never cause overrun. Entries in the FIFO therefore always have pe_o=fe_o=0.
- Undefined: all frames are pushed with their flags, and err_cnt_o is tied to 0.

Test Plan:
- Reset, then 8-bit, no parity, 1 stop: frame_i=0x1A5, valid_i pulse -> next cycle empty_o=0, data_o=0xA5, pe_o=0, fe_o=0, count_o=1; pop_i -> empty_o=1.
- 7-bit, even parity, 2 stops: data 0x55 (4 ones), parity_i=1 -> pe_o=1; parity_i=0 -> pe_o=0; stop bits 0b01 -> fe_o=1.
- DEPTH=8: push 0x00..0x07 -> full_o=1, count_o=8; push 0x08 -> overrun_o=1 and data_o=0x00; pop all 8 -> order 0x00..0x07; clear_ovr_i -> overrun_o=0.
- Full FIFO with valid_i and pop_i in the same cycle -> count_o stays 8, overrun_o=0, last pop returns the new byte.
- Empty FIFO with pop_i -> no change. Push and pop in the same cycle on empty -> count_o=1. Reset asserted with 3 entries -> count_o=0 next cycle.
- RX_ERR_DROP_EN: 3 frames with bad stop bits, 1 good frame -> count_o=1, err_cnt_o=3; 300 bad frames -> err_cnt_o=255.
